// File: rtl/aes_batch_sequencer_if.sv
// Core-side bus between the batch sequencer (master) and the AES core (slave).
interface aes_batch_sequencer_if #(
    parameter int pPT_WIDTH = 128
);
    logic                 aes_load_o;
    logic [pPT_WIDTH-1:0] aes_pt_o;
    logic                 aes_busy_i;
    logic [pPT_WIDTH-1:0] aes_ct_i;

    modport master (
        output aes_load_o,
        output aes_pt_o,
        input  aes_busy_i,
        input  aes_ct_i
    );

    modport slave (
        input  aes_load_o,
        input  aes_pt_o,
        output aes_busy_i,
        output aes_ct_i
    );
endinterface

// File: rtl/aes_batch_sequencer.sv
// Runs a programmed batch of back-to-back AES encryptions, with optional ciphertext chaining,
// an idle gap between operations and a side-channel trigger window around each one.
//   state     | meaning
//   IDLE      | waiting for an accepted start
//   LOAD      | one-cycle load strobe to the core, trigger window opens
//   WAIT_BUSY | waiting for core busy to rise, bounded by pTMO
//   RUN       | core encrypting; busy falling captures the ciphertext
//   GAP       | idle cycles between encryptions
//   DONE      | one-cycle completion pulse (also ends a timed-out batch)
module aes_batch_sequencer #(
    parameter int pPT_WIDTH  = 128,
    parameter int pCNT_WIDTH = 16,
    parameter int pDLY_WIDTH = 8,
    parameter int pTMO       = 4
) (
    input  logic                  crypto_clk,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [pCNT_WIDTH-1:0] count_i,
    input  logic                  chain_i,
    input  logic [pDLY_WIDTH-1:0] delay_i,
    input  logic [pPT_WIDTH-1:0]  pt_i,
    aes_batch_sequencer_if.master core,
    output logic                  trigger_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [pPT_WIDTH-1:0]  ct_o,
    output logic [pCNT_WIDTH-1:0] iter_o
);

    localparam int TMO_W = $clog2(pTMO + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_BUSY,
        S_RUN,
        S_GAP,
        S_DONE
    } state_t;

    state_t                state, state_next;
    logic [pCNT_WIDTH-1:0] count_q;
    logic                  chain_q;
    logic [pDLY_WIDTH-1:0] delay_q;
    logic [pPT_WIDTH-1:0]  wpt, wpt_next;
    logic [pDLY_WIDTH-1:0] gap_cnt;
    logic [TMO_W-1:0]      tmo_cnt;
    logic                  accept;
    logic                  capture;
    logic                  set_err;

    always_comb begin
        state_next = state;
        wpt_next   = wpt;
        accept     = 1'b0;
        capture    = 1'b0;
        set_err    = 1'b0;

        case (state)
            S_IDLE: begin
                if (start_i && !core.aes_busy_i && !abort_i) begin
                    accept     = 1'b1;
                    wpt_next   = pt_i;
                    state_next = S_LOAD;
                end
            end
            S_LOAD: state_next = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (core.aes_busy_i) begin
                    state_next = S_RUN;
                end else if (tmo_cnt == TMO_W'(pTMO - 1)) begin
                    set_err    = 1'b1;
                    state_next = S_DONE;
                end
            end
            S_RUN: begin
                if (!core.aes_busy_i) begin
                    capture = 1'b1;
                    if (chain_q) wpt_next = core.aes_ct_i;
                    if (iter_o + pCNT_WIDTH'(1) == count_q) state_next = S_DONE;
                    else if (delay_q == '0)                 state_next = S_LOAD;
                    else                                    state_next = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_cnt == pDLY_WIDTH'(1)) state_next = S_LOAD;
            end
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase

        // Abort beats every other transition and must leave ct/iter/err/plaintext untouched.
        if (state != S_IDLE && abort_i) begin
            state_next = S_IDLE;
            wpt_next   = wpt;
            capture    = 1'b0;
            set_err    = 1'b0;
        end
    end

    always_ff @(posedge crypto_clk) begin
        if (reset_i) begin
            state           <= S_IDLE;
            count_q         <= '0;
            chain_q         <= 1'b0;
            delay_q         <= '0;
            wpt             <= '0;
            gap_cnt         <= '0;
            tmo_cnt         <= '0;
            core.aes_load_o <= 1'b0;
            core.aes_pt_o   <= '0;
            trigger_o       <= 1'b0;
            busy_o          <= 1'b0;
            done_o          <= 1'b0;
            err_o           <= 1'b0;
            ct_o            <= '0;
            iter_o          <= '0;
        end else begin
            state <= state_next;
            wpt   <= wpt_next;

            if (accept) begin
                count_q <= (count_i == '0) ? pCNT_WIDTH'(1) : count_i;
                chain_q <= chain_i;
                delay_q <= delay_i;
            end

            if (state == S_WAIT_BUSY) tmo_cnt <= tmo_cnt + TMO_W'(1);
            else                      tmo_cnt <= '0;

            if (state == S_RUN && state_next == S_GAP) gap_cnt <= delay_q;
            else if (state == S_GAP)                   gap_cnt <= gap_cnt - pDLY_WIDTH'(1);

            // Outputs are registered decodes of the next state so they line up with it.
            core.aes_load_o <= (state_next == S_LOAD);
            trigger_o       <= (state_next == S_LOAD) || (state_next == S_WAIT_BUSY) ||
                               (state_next == S_RUN);
            busy_o          <= (state_next != S_IDLE);
            done_o          <= (state_next == S_DONE);

            if (state_next == S_LOAD) core.aes_pt_o <= wpt_next;

            if (accept)       err_o <= 1'b0;
            else if (set_err) err_o <= 1'b1;

            if (accept)       iter_o <= '0;
            else if (capture) iter_o <= iter_o + pCNT_WIDTH'(1);

            if (capture) ct_o <= core.aes_ct_i;
        end
    end

endmodule

// File: tb/tb_aes_batch_sequencer.sv
// Scoreboard bench for aes_batch_sequencer: a latency-programmable core stub, expected
// plaintexts and batch results queued at start, compared when loads and done pulses appear.
module tb_aes_batch_sequencer;

    localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    typedef struct {
        logic [127:0] ct;
        logic [15:0]  iter;
        logic         err;
    } done_exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [15:0]  count = '0;
    logic         chain = 1'b0;
    logic [7:0]   delay = '0;
    logic [127:0] pt = '0;
    logic         trigger, busy, done, err;
    logic [127:0] ct;
    logic [15:0]  iter;

    logic         stub_en = 1'b1;
    logic         stub_busy = 1'b0;
    logic         force_busy = 1'b0;
    logic [127:0] stub_ct = '0;
    logic [127:0] stub_pt = '0;
    int           lat = 4;

    logic [127:0] pt_q[$];
    done_exp_t    done_q[$];
    logic [127:0] model_ct = '0;

    int n_chk = 0;
    int n_pass = 0;
    int load_cnt = 0;
    int done_cnt = 0;
    int gap_run = 0;
    int gap_exp = 0;
    bit first_load = 1'b1;

    aes_batch_sequencer_if #(.pPT_WIDTH(128)) core_bus ();
    assign core_bus.aes_busy_i = stub_busy | force_busy;
    assign core_bus.aes_ct_i   = stub_ct;

    aes_batch_sequencer #(
        .pPT_WIDTH (128),
        .pCNT_WIDTH(16),
        .pDLY_WIDTH(8),
        .pTMO      (4)
    ) dut (
        .crypto_clk(clk),
        .reset_i   (rst),
        .start_i   (start),
        .abort_i   (abort),
        .count_i   (count),
        .chain_i   (chain),
        .delay_i   (delay),
        .pt_i      (pt),
        .core      (core_bus),
        .trigger_o (trigger),
        .busy_o    (busy),
        .done_o    (done),
        .err_o     (err),
        .ct_o      (ct),
        .iter_o    (iter)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Stand-in cipher: exact FIPS-197 vector for its plaintext, a fixed scramble otherwise.
    function automatic logic [127:0] stub_enc(input logic [127:0] p);
        if (p == FIPS_PT) return FIPS_CT;
        return {p[96:0], p[127:97]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0 ^
               {4{p[31:0] + 32'h9e3779b9}};
    endfunction

    initial begin : core_stub
        forever begin
            @(negedge clk);
            if (core_bus.aes_load_o && stub_en) begin
                stub_pt = core_bus.aes_pt_o;
                @(posedge clk);
                #1 stub_busy = 1'b1;
                repeat (lat) @(posedge clk);
                #1 stub_busy = 1'b0;
                stub_ct = stub_enc(stub_pt);
            end
        end
    end

    initial begin : monitor
        done_exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (core_bus.aes_load_o) begin
                    load_cnt++;
                    if (!first_load) check_val("gap_cycles", gap_run, gap_exp);
                    first_load = 1'b0;
                    gap_run = 0;
                    if (pt_q.size() > 0) check_val("load_pt", core_bus.aes_pt_o, pt_q.pop_front());
                    else check_val("load_unexpected", pt_q.size(), 1);
                    check_val("trigger_at_load", trigger, 1'b1);
                end else if (busy && !trigger && !done) begin
                    gap_run++;
                end
                if (done) begin
                    done_cnt++;
                    if (done_q.size() > 0) begin
                        e = done_q.pop_front();
                        check_val("done_ct", ct, e.ct);
                        check_val("done_iter", iter, e.iter);
                        check_val("done_err", err, e.err);
                        check_val("done_trigger_low", trigger, 1'b0);
                    end else begin
                        check_val("done_unexpected", done_q.size(), 1);
                    end
                end
            end
        end
    end

    task automatic push_batch(input logic [15:0] n, input logic ch, input logic [127:0] p0);
        logic [127:0] p, c;
        int eff;
        eff = (n == 16'd0) ? 1 : int'(n);
        p = p0;
        c = model_ct;
        for (int i = 0; i < eff; i++) begin
            pt_q.push_back(p);
            c = stub_enc(p);
            if (ch) p = c;
        end
        done_q.push_back('{c, 16'(eff), 1'b0});
        model_ct = c;
    endtask

    task automatic start_batch(input logic [15:0] n, input logic ch, input logic [7:0] d,
                               input logic [127:0] p, input bit hold);
        count = n;
        chain = ch;
        delay = d;
        pt = p;
        gap_exp = int'(d);
        first_load = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        check_val("start_to_load", core_bus.aes_load_o, 1'b1);
        check_val("err_cleared_on_start", err, 1'b0);
        check_val("iter_cleared_on_start", iter, 16'd0);
    endtask

    task automatic wait_done(input int budget, output int cycles);
        bit seen;
        seen = 1'b0;
        cycles = 0;
        while (cycles < budget && !seen) begin
            @(negedge clk);
            cycles++;
            if (done) seen = 1'b1;
        end
        if (!seen) check_val("done_timeout", seen, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_load"}, core_bus.aes_load_o, 1'b0);
        check_val({tag, "_pt"}, core_bus.aes_pt_o, 128'h0);
        check_val({tag, "_trigger"}, trigger, 1'b0);
        check_val({tag, "_busy"}, busy, 1'b0);
        check_val({tag, "_done"}, done, 1'b0);
        check_val({tag, "_err"}, err, 1'b0);
        check_val({tag, "_ct"}, ct, 128'h0);
        check_val({tag, "_iter"}, iter, 16'd0);
    endtask

    initial begin : main
        int cyc, l0, d0;
        logic [127:0] p2, exp3;
        bit found;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single encryption of the FIPS-197 vector.
        l0 = load_cnt; d0 = done_cnt; lat = 4;
        push_batch(16'd1, 1'b0, FIPS_PT);
        start_batch(16'd1, 1'b0, 8'd0, FIPS_PT, 1'b0);
        wait_done(100, cyc);
        check_val("fips_ct", ct, FIPS_CT);
        check_val("fips_iter", iter, 16'd1);
        @(negedge clk);
        check_val("done_one_cycle", done, 1'b0);
        check_val("busy_back_idle", busy, 1'b0);
        repeat (4) @(negedge clk);
        check_val("fips_loads", load_cnt - l0, 1);
        check_val("fips_dones", done_cnt - d0, 1);

        // Chained triple encryption with a 5-cycle gap.
        l0 = load_cnt; lat = 3;
        p2 = 128'hdeadbeef_01234567_89abcdef_cafef00d;
        exp3 = stub_enc(stub_enc(stub_enc(p2)));
        push_batch(16'd3, 1'b1, p2);
        start_batch(16'd3, 1'b1, 8'd5, p2, 1'b0);
        wait_done(200, cyc);
        check_val("chain_ct", ct, exp3);
        check_val("chain_iter", iter, 16'd3);
        repeat (4) @(negedge clk);
        check_val("chain_loads", load_cnt - l0, 3);

        // count=0 runs once; start held across the whole batch starts only one batch.
        l0 = load_cnt; d0 = done_cnt; lat = 2;
        push_batch(16'd0, 1'b0, 128'h1);
        start_batch(16'd0, 1'b0, 8'd0, 128'h1, 1'b1);
        wait_done(100, cyc);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check_val("count0_loads", load_cnt - l0, 1);
        check_val("count0_dones", done_cnt - d0, 1);

        // Core never goes busy: timeout with done 6 cycles after start.
        stub_en = 1'b0;
        pt_q.push_back(128'h55);
        done_q.push_back('{model_ct, 16'd0, 1'b1});
        start_batch(16'd2, 1'b0, 8'd0, 128'h55, 1'b0);
        wait_done(20, cyc);
        check_val("tmo_latency", cyc + 1, 6);
        check_val("tmo_err", err, 1'b1);
        repeat (3) @(negedge clk);
        check_val("tmo_err_sticky", err, 1'b1);
        stub_en = 1'b1;
        push_batch(16'd2, 1'b0, 128'h77);
        start_batch(16'd2, 1'b0, 8'd1, 128'h77, 1'b0);
        wait_done(100, cyc);
        check_val("post_tmo_err", err, 1'b0);
        repeat (4) @(negedge clk);

        // Abort during the 4th RUN.
        l0 = load_cnt; d0 = done_cnt; lat = 4;
        for (int i = 0; i < 4; i++) pt_q.push_back(128'h99);
        model_ct = stub_enc(128'h99);
        start_batch(16'd10, 1'b0, 8'd2, 128'h99, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            #1;
            if (load_cnt - l0 >= 4) found = 1'b1;
        end
        check_val("abort_reach_4th_load", found, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check_val("abort_in_run", trigger && busy && !core_bus.aes_load_o, 1'b1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_val("abort_busy", busy, 1'b0);
        check_val("abort_trigger", trigger, 1'b0);
        check_val("abort_iter", iter, 16'd3);
        check_val("abort_ct", ct, model_ct);
        repeat (8) @(negedge clk);
        check_val("abort_no_done", done_cnt - d0, 0);

        // Reset while in GAP.
        lat = 2;
        push_batch(16'd3, 1'b0, 128'habc);
        start_batch(16'd3, 1'b0, 8'd8, 128'habc, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (busy && !trigger && !done) found = 1'b1;
        end
        check_val("reach_gap", found, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("gap_reset");
        rst = 1'b0;
        pt_q.delete();
        done_q.delete();
        model_ct = '0;
        first_load = 1'b1;
        repeat (2) @(negedge clk);

        // Start is ignored while the core reports busy.
        l0 = load_cnt;
        force_busy = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_val("busy_start_ignored", busy, 1'b0);
        repeat (3) @(negedge clk);
        check_val("busy_start_no_load", load_cnt - l0, 0);
        force_busy = 1'b0;

        // Recovery batch after reset.
        push_batch(16'd2, 1'b1, FIPS_PT);
        start_batch(16'd2, 1'b1, 8'd0, FIPS_PT, 1'b0);
        wait_done(100, cyc);
        check_val("recover_ct", ct, stub_enc(FIPS_CT));
        repeat (4) @(negedge clk);
        check_val("pt_queue_drained", pt_q.size(), 0);
        check_val("done_queue_drained", done_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
